// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC [-> WB] -> FETCH, with HALT on an all-zero word.
// Optional single-step mode behind `SINGLE_STEP_EN` adds a step input and a PAUSE state (code 6).
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr_in,
    output logic [31:0] ir,
    input  logic        dec_reg_write,
    input  logic        dec_is_branch,
    input  logic        dec_is_jump,
    input  logic [15:0] dec_imm,
    input  logic        alu_zero,
    output logic        alu_en,
    output logic        rf_we,
    output logic [15:0] pc,
    output logic        busy,
    output logic        halted,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
`ifdef SINGLE_STEP_EN
        , S_PAUSE = 3'd6
`endif
    } state_e;

    // Where an instruction goes once it has retired.
`ifdef SINGLE_STEP_EN
    localparam state_e S_RESUME = S_PAUSE;
`else
    localparam state_e S_RESUME = S_FETCH;
`endif

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= 16'h0000;
            ir_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (ir_q == 32'h0000_0000) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // Jump wins over branch; a not-taken branch still advances pc here, skipping WB.
                if (dec_is_jump) begin
                    pc_d    = dec_imm;
                    state_d = S_RESUME;
                end else if (dec_is_branch) begin
                    pc_d    = alu_zero ? dec_imm : pc_q + 16'd4;
                    state_d = S_RESUME;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d    = pc_q + 16'd4;
                state_d = S_RESUME;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) state_d = S_FETCH;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Everything is decoded from state; rf_we also drops during reset so an in-flight write never lands.
    assign imem_req = (state_q == S_FETCH);
    assign alu_en   = (state_q == S_EXEC);
    assign rf_we    = (state_q == S_WB) && dec_reg_write && !rst;
    assign halted   = (state_q == S_HALT);
`ifdef SINGLE_STEP_EN
    assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_WB) || (state_q == S_PAUSE);
`else
    assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_WB);
`endif
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign state    = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model expands each instruction into per-cycle stimulus and
// expected outputs {state, imem_req, alu_en, rf_we, busy, halted, pc, ir}, compared every cycle.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, imem_req, imem_ack;
    logic [31:0] instr_in, ir;
    logic        dec_reg_write, dec_is_branch, dec_is_jump, alu_zero;
    logic [15:0] dec_imm, pc;
    logic        alu_en, rf_we, busy, halted;
    logic [2:0]  state;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
        .instr_in(instr_in), .ir(ir), .dec_reg_write(dec_reg_write), .dec_is_branch(dec_is_branch),
        .dec_is_jump(dec_is_jump), .dec_imm(dec_imm), .alu_zero(alu_zero), .alu_en(alu_en),
        .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        ack;
        logic [31:0] instr;
        logic        rw;
        logic        br;
        logic        jmp;
        logic        zero;
        logic [15:0] imm;
    } stim_t;

    stim_t       stim_q[$];
    logic [55:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    stim_t       cur;
    logic [55:0] e, o;

    function automatic logic [55:0] pack_exp(input logic [2:0] st, input logic req, input logic alu,
                                             input logic we, input logic [15:0] p, input logic [31:0] i);
        logic bsy, hlt;
        bsy = (st >= 3'd1) && (st <= 3'd4);
        hlt = (st == 3'd5);
        return {st, req, alu, we, bsy, hlt, p, i};
    endfunction

    function automatic logic [55:0] sample();
        return {state, imem_req, alu_en, rf_we, busy, halted, pc, ir};
    endfunction

    task automatic drive(input stim_t s);
        rst           = s.rst;
        start         = s.start;
        imem_ack      = s.ack;
        instr_in      = s.instr;
        dec_reg_write = s.rw;
        dec_is_branch = s.br;
        dec_is_jump   = s.jmp;
        alu_zero      = s.zero;
        dec_imm       = s.imm;
    endtask

    task automatic push(input stim_t s, input logic [55:0] x);
        stim_q.push_back(s);
        exp_q.push_back(x);
    endtask

    // IDLE cycle; start optionally raised.
    task automatic model_idle(input logic st);
        stim_t s;
        s = '0;
        s.start = st;
        s.ack = 1'($urandom_range(0, 1));
        s.instr = $urandom;
        push(s, pack_exp(3'd0, 1'b0, 1'b0, 1'b0, m_pc, m_ir));
    endtask

    // One instruction starting in FETCH: d wait cycles before ack; optional reset during WB;
    // an all-zero word halts for halt_cycles cycles, the last of which carries rst.
    task automatic model_instr(input logic [31:0] instr, input int d, input logic rw, input logic br,
                               input logic jmp, input logic zero, input logic [15:0] imm,
                               input bit rst_in_wb, input int halt_cycles);
        stim_t s;
        s = '0;
        s.rw = rw; s.br = br; s.jmp = jmp; s.zero = zero; s.imm = imm;
        for (int k = 0; k < d; k++) begin
            s.start = 1'($urandom_range(0, 1));
            s.ack = 1'b0;
            s.instr = $urandom;
            push(s, pack_exp(3'd1, 1'b1, 1'b0, 1'b0, m_pc, m_ir));
        end
        s.start = 1'($urandom_range(0, 1));
        s.ack = 1'b1;
        s.instr = instr;
        push(s, pack_exp(3'd1, 1'b1, 1'b0, 1'b0, m_pc, m_ir));
        m_ir = instr;
        s.ack = 1'($urandom_range(0, 1));
        s.instr = $urandom;
        push(s, pack_exp(3'd2, 1'b0, 1'b0, 1'b0, m_pc, m_ir));
        if (instr == 32'h0) begin
            for (int k = 0; k < halt_cycles; k++) begin
                s.start = 1'b1;
                s.ack = 1'($urandom_range(0, 1));
                s.rst = (k == halt_cycles - 1);
                push(s, pack_exp(3'd5, 1'b0, 1'b0, 1'b0, m_pc, m_ir));
            end
            m_pc = 16'h0;
            m_ir = 32'h0;
            return;
        end
        s.ack = 1'($urandom_range(0, 1));
        push(s, pack_exp(3'd3, 1'b0, 1'b1, 1'b0, m_pc, m_ir));
        if (jmp) m_pc = imm;
        else if (br) m_pc = zero ? imm : m_pc + 16'd4;
        else begin
            s.rst = rst_in_wb;
            push(s, pack_exp(3'd4, 1'b0, 1'b0, rw && !rst_in_wb, m_pc, m_ir));
            if (rst_in_wb) begin
                m_pc = 16'h0;
                m_ir = 32'h0;
            end else begin
                m_pc = m_pc + 16'd4;
            end
        end
    endtask

    task automatic test_reset();
        drive('0);
        rst = 1'b1;
        start = 1'b1;
        imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (sample() !== pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0)) begin
            bad++;
            $display("FAIL reset: got %h want %h", sample(), pack_exp(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        end
        @(posedge clk);
        #1;
        m_pc = 16'h0;
        m_ir = 32'h0;
        model_idle(1'b0);
        model_idle(1'b0);
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL reset_idle: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_basic();
        model_idle(1'b1);
        model_instr(32'h0000_0033, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
        model_instr(32'h0000_0033, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 0);
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL alu_basic: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ack_delay();
        model_instr(32'h1234_5678, 3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
        model_instr(32'h0BAD_F00D, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL ack_delay: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        model_instr(32'h0000_0063, 0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 0);
        model_instr(32'h0000_1063, 0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b0, 0);
        model_instr(32'h0000_006F, 0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 0);
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL branch_jump: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] w;
            kind = $urandom_range(0, 2);
            w = $urandom | 32'h1;
            case (kind)
                0: model_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                               1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 0);
                1: model_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                               1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 0);
                default: model_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                                     16'($urandom), 1'b0, 0);
            endcase
        end
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL random: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pc_wrap_and_wb_reset();
        model_instr(32'h0000_006F, 1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFC, 1'b0, 0);
        model_instr(32'h0000_0033, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
        model_instr(32'h0000_0033, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 0);
        model_idle(1'b0);
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL wrap_wb_reset: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        model_idle(1'b1);
        model_instr(32'h0000_006F, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 0);
        model_instr(32'h0000_0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 5);
        model_idle(1'b0);
        model_idle(1'b1);
        model_instr(32'h0000_0033, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
        while (stim_q.size() > 0) begin
            cur = stim_q.pop_front(); drive(cur); @(negedge clk);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL halt: got %h want %h", o, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_ack_delay();
        test_branch_jump();
        test_random();
        test_pc_wrap_and_wb_reset();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL provide the following ports:
- start input 1: leave IDLE, begin fetching at pc.
- imem_req output 1: instruction fetch request.
- imem_ack input 1: fetch data valid on instr_in this cycle.
- instr_in input 32: fetched instruction word.
- ir output 32: instruction register, feeds the decoder.
- dec_reg_write input 1, dec_is_branch input 1, dec_is_jump input 1, dec_imm input 16: decoder outputs for ir.
- alu_zero input 1: ALU result equals zero.
- alu_en output 1: ALU operands and result are valid this cycle.
- rf_we output 1: register-file write strobe.
- pc output 16: program counter.
- busy output 1: high when not IDLE and not HALT.
- halted output 1: high in HALT.
- state output 3: current FSM state code.

Function
REQ-003 The FSM SHALL have six states with these codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-004 IDLE SHALL go to FETCH when start=1; otherwise it SHALL hold, and start SHALL be ignored in every other state.
REQ-005 FETCH SHALL hold imem_req=1 until imem_ack=1; on ack it SHALL load ir<=instr_in and go to DECODE; ack outside FETCH SHALL be ignored.
REQ-006 ack in the same cycle FETCH is entered SHALL be honoured, giving a minimum FETCH length of one cycle.
REQ-007 DECODE SHALL last one cycle; if ir==32'h0 it SHALL go to HALT, else to EXEC.
REQ-008 EXEC SHALL last one cycle with alu_en=1.
REQ-009 In EXEC, if dec_is_jump=1, pc SHALL load dec_imm and the FSM SHALL go to FETCH.
REQ-010 In EXEC, if dec_is_branch=1 and alu_zero=1, pc SHALL load dec_imm and the FSM SHALL go to FETCH; jump SHALL take priority when both dec_is_jump and dec_is_branch are set.
REQ-011 In EXEC, if dec_is_branch=1 and alu_zero=0, pc SHALL become pc+4 and the FSM SHALL go to FETCH.
REQ-012 In EXEC, in all other cases, the FSM SHALL go to WB.
REQ-013 WB SHALL last one cycle with rf_we=dec_reg_write and pc<=pc+4, then go to FETCH.
REQ-014 pc arithmetic SHALL be modulo 2^16: 16'hFFFC+4 SHALL give 16'h0000 with no flag.
REQ-015 HALT SHALL be absorbing until rst.
REQ-016 Cycle counts per instruction with single-cycle ack SHALL be:
- ALU instruction: 4 cycles.
- Branch or jump: 3 cycles.
- HALT: DECODE plus 1 cycle.
REQ-017 rf_we and alu_en SHALL never be asserted outside WB and EXEC respectively.
REQ-018 All outputs SHALL be registered or decoded from state only, with no combinational path from imem_ack to imem_req.

Reset
REQ-019 When rst=1, the next cycle SHALL give: state=IDLE, pc=16'h0000, ir=32'h0, imem_req=0, rf_we=0, alu_en=0, busy=0, halted=0.
REQ-020 rst SHALL take priority over every transition, including mid-FETCH with ack pending and in HALT; a write in progress SHALL be suppressed.

Configuration
REQ-021 When SINGLE_STEP_EN is defined, the block SHALL add an input step (1 bit), and the exit from WB, or from EXEC to FETCH, SHALL go to a PAUSE state (code 6) that waits for step=1 before entering FETCH; busy SHALL be 1 in PAUSE.
REQ-022 When SINGLE_STEP_EN is undefined, the step port and the PAUSE state SHALL be absent and code 6 SHALL follow REQ-003.

Verification
REQ-023 Reset, then start pulse, ack same cycle, instr 0x00000033 with dec_reg_write=1 -> states 1,2,3,4,1; rf_we high only in WB; pc=4.
REQ-024 Ack delayed 3 cycles -> imem_req high for 4 cycles; ir loads only on the ack cycle.
REQ-025 Branch with dec_imm=0x0040: alu_zero=1 -> pc=0x0040, no rf_we; alu_zero=0 -> pc=old+4.
REQ-026 Jump with dec_is_branch also set, dec_imm=0x0100 -> pc=0x0100, 3 cycles total.
REQ-027 Fetch of 0x00000000 -> HALT, halted=1, start ignored; then rst -> IDLE, pc=0.
REQ-028 pc=0xFFFC executing an ALU instruction -> pc=0x0000; rst asserted in WB -> rf_we=0 that cycle and IDLE on the next.
